// File: rtl/sdram_aref_pkg.sv
// Shared SDRAM command encodings and auto-refresh FSM state type.
// Encodings are {CS_n,RAS_n,CAS_n,WE_n}; A10 selects all banks on PRECHARGE.
package sdram_aref_pkg;

    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AUTO_REF  = 4'b0001;
    localparam logic [3:0] CMD_MRSET     = 4'b0000;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_READ      = 4'b0101;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;

    localparam logic [11:0] ADDR_ALL_BANKS = 12'h400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_BURST
    } aref_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh period timer: counts 0..CNT_REF_MAX-1 while enabled, held at 0 otherwise.
// Ports: clk_i, rst_i (sync, active-high), en_i; expire_o high on the last count.
module sdram_ref_timer #(
    parameter int CNT_REF_MAX = 750
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int TW = (CNT_REF_MAX > 1) ? $clog2(CNT_REF_MAX) : 1;
    localparam logic [TW-1:0] LAST = TW'(CNT_REF_MAX - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sdram_aref.sv
// Periodic SDRAM auto-refresh engine: request, PRECHARGE-all, two AUTO_REFs.
// Ports: sclk, s_rst, flag_init_end, ref_en in; ref_req, aref_cmd/addr/bank,
// flag_ref_end, ref_miss out (all registered).
module sdram_aref
    import sdram_aref_pkg::*;
#(
    parameter int CNT_REF_MAX = 750,
    parameter int T_RP        = 2,
    parameter int T_RC        = 4
) (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic        flag_init_end,
    input  logic        ref_en,
    output logic        ref_req,
    output logic [3:0]  aref_cmd,
    output logic [11:0] aref_addr,
    output logic [1:0]  aref_bank,
    output logic        flag_ref_end,
    output logic        ref_miss
);

    localparam int END_STEP = T_RP + 2 * T_RC;
    localparam int SW = $clog2(END_STEP + 1);
    localparam logic [SW-1:0] S_AREF1 = SW'(T_RP);
    localparam logic [SW-1:0] S_AREF2 = SW'(T_RP + T_RC);
    localparam logic [SW-1:0] S_END   = SW'(END_STEP);

    aref_state_e state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic pend_q, pend_d;
    logic miss_q, miss_d;
    logic req_q, req_d;
    logic [3:0] cmd_q, cmd_d;
    logic [11:0] addr_q, addr_d;
    logic end_q, end_d;
    logic expire;
    logic grant;

    sdram_ref_timer #(
        .CNT_REF_MAX(CNT_REF_MAX)
    ) u_timer (
        .clk_i   (sclk),
        .rst_i   (s_rst),
        .en_i    (state_q != ST_IDLE),
        .expire_o(expire)
    );

    // ref_req is only ever high in ARM, so this is the real grant.
    assign grant = req_q & ref_en;

    always_comb begin
        state_d = state_q;
        step_d  = '0;
        pend_d  = pend_q;
        miss_d  = miss_q;
        req_d   = 1'b0;
        cmd_d   = CMD_NOP;
        addr_d  = '0;
        end_d   = 1'b0;

        // A new expiry wins over a same-cycle grant clear.
        if (grant) pend_d = 1'b0;
        if (expire) pend_d = 1'b1;
        if (expire && pend_q && !grant) miss_d = 1'b1;

        req_d = (state_q == ST_ARM) && pend_q && !grant;

        unique case (state_q)
            ST_IDLE: begin
                if (flag_init_end) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (grant) state_d = ST_BURST;
            end
            ST_BURST: begin
                if (step_q == S_END) begin
                    state_d = ST_ARM;
                    end_d   = 1'b1;
                end else begin
                    step_d = step_q + 1'b1;
                end
                if (step_q == '0) begin
                    cmd_d  = CMD_PRECHARGE;
                    addr_d = ADDR_ALL_BANKS;
                end else if (step_q == S_AREF1 || step_q == S_AREF2) begin
                    cmd_d = CMD_AUTO_REF;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            pend_q  <= 1'b0;
            miss_q  <= 1'b0;
            req_q   <= 1'b0;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            pend_q  <= pend_d;
            miss_q  <= miss_d;
            req_q   <= req_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
        end
    end

    assign ref_req      = req_q;
    assign aref_cmd     = cmd_q;
    assign aref_addr    = addr_q;
    assign aref_bank    = 2'b00;
    assign flag_ref_end = end_q;
    assign ref_miss     = miss_q;

endmodule

// File: tb/tb_sdram_aref.sv
// Scoreboard bench for sdram_aref with a 20-cycle refresh period.
// Expected burst commands are queued at grant time and matched each cycle.
module tb_sdram_aref;
    import sdram_aref_pkg::*;

    logic        sclk = 1'b0;
    logic        s_rst = 1'b1;
    logic        flag_init_end = 1'b0;
    logic        ref_en = 1'b0;
    logic        ref_req;
    logic [3:0]  aref_cmd;
    logic [11:0] aref_addr;
    logic [1:0]  aref_bank;
    logic        flag_ref_end;
    logic        ref_miss;

    always #5 sclk = ~sclk;

    sdram_aref #(
        .CNT_REF_MAX(20),
        .T_RP       (2),
        .T_RC       (4)
    ) dut (
        .sclk         (sclk),
        .s_rst        (s_rst),
        .flag_init_end(flag_init_end),
        .ref_en       (ref_en),
        .ref_req      (ref_req),
        .aref_cmd     (aref_cmd),
        .aref_addr    (aref_addr),
        .aref_bank    (aref_bank),
        .flag_ref_end (flag_ref_end),
        .ref_miss     (ref_miss)
    );

    int cyc = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cyc %0d",
                     tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int         c;
        logic [3:0] cmd;
        logic [11:0] addr;
        logic       fl;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    bit   mon_on = 1'b0;

    // Queue the first n events of a burst granted at edge k.
    task automatic push_burst(input int k, input int n);
        exp_t e;
        e.c = k + 1; e.cmd = CMD_PRECHARGE; e.addr = 12'h400; e.fl = 1'b0;
        if (n >= 1) sb.push_back(e);
        e.c = k + 3; e.cmd = CMD_AUTO_REF; e.addr = 12'h000;
        if (n >= 2) sb.push_back(e);
        e.c = k + 7;
        if (n >= 3) sb.push_back(e);
        e.c = k + 11; e.cmd = CMD_NOP; e.fl = 1'b1;
        if (n >= 4) sb.push_back(e);
    endtask

    always @(negedge sclk) begin
        if (mon_on) begin
            chk("bank", 32'(aref_bank), 32'd0);
            if (sb.size() > 0 && sb[0].c < cyc) begin
                chk("sb_missed", 32'(sb[0].c), 32'(cyc));
                me = sb.pop_front();
            end
            if (sb.size() > 0 && sb[0].c == cyc) begin
                me = sb.pop_front();
                chk("cmd", 32'(aref_cmd), 32'(me.cmd));
                chk("addr", 32'(aref_addr), 32'(me.addr));
                chk("ref_end", 32'(flag_ref_end), 32'(me.fl));
            end else begin
                chk("cmd_nop", 32'(aref_cmd), 32'(CMD_NOP));
                chk("addr_zero", 32'(aref_addr), 32'd0);
                chk("ref_end_low", 32'(flag_ref_end), 32'd0);
            end
        end
    end

    task automatic to_cyc(input int target);
        while (cyc < target) @(negedge sclk);
    endtask

    int t;
    int g;
    int t2;

    initial begin
        s_rst = 1'b1;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        chk("rst_req", 32'(ref_req), 32'd0);
        chk("rst_cmd", 32'(aref_cmd), 32'(CMD_NOP));
        chk("rst_addr", 32'(aref_addr), 32'd0);
        chk("rst_bank", 32'(aref_bank), 32'd0);
        chk("rst_end", 32'(flag_ref_end), 32'd0);
        chk("rst_miss", 32'(ref_miss), 32'd0);
        s_rst = 1'b0;
        mon_on = 1'b1;

        repeat (100) begin
            @(negedge sclk);
            chk("req_noinit", 32'(ref_req), 32'd0);
        end

        flag_init_end = 1'b1;
        t = cyc + 1;
        @(negedge sclk);
        flag_init_end = 1'b0;
        to_cyc(t + 20);
        chk("req_t20", 32'(ref_req), 32'd0);
        @(negedge sclk);
        chk("req_t21", 32'(ref_req), 32'd1);

        ref_en = 1'b1;
        for (int n = 0; n <= 10; n++) push_burst(t + 22 + 20 * n, 4);
        to_cyc(t + 23);
        chk("req_after_grant", 32'(ref_req), 32'd0);
        to_cyc(t + 223);
        ref_en = 1'b0;
        to_cyc(t + 234);
        chk("miss_periodic", 32'(ref_miss), 32'd0);
        chk("sb_periodic", 32'(sb.size()), 32'd0);

        to_cyc(t + 241);
        chk("req_starve", 32'(ref_req), 32'd1);
        to_cyc(t + 259);
        chk("miss_before", 32'(ref_miss), 32'd0);
        @(negedge sclk);
        chk("miss_second_exp", 32'(ref_miss), 32'd1);
        to_cyc(t + 286);
        chk("req_held", 32'(ref_req), 32'd1);
        ref_en = 1'b1;
        push_burst(t + 287, 4);
        @(negedge sclk);
        ref_en = 1'b0;
        to_cyc(t + 299);
        chk("sb_starve", 32'(sb.size()), 32'd0);
        chk("miss_sticky", 32'(ref_miss), 32'd1);

        to_cyc(t + 301);
        chk("req_rerise", 32'(ref_req), 32'd1);
        ref_en = 1'b1;
        g = t + 302;
        push_burst(g, 2);
        @(negedge sclk);
        ref_en = 1'b0;
        to_cyc(g + 3);
        s_rst = 1'b1;
        @(negedge sclk);
        s_rst = 1'b0;
        chk("rst_mid_req", 32'(ref_req), 32'd0);
        chk("rst_mid_miss", 32'(ref_miss), 32'd0);
        repeat (60) begin
            @(negedge sclk);
            chk("req_no_rearm", 32'(ref_req), 32'd0);
        end

        flag_init_end = 1'b1;
        t2 = cyc + 1;
        @(negedge sclk);
        flag_init_end = 1'b0;
        to_cyc(t2 + 20);
        chk("rearm_t20", 32'(ref_req), 32'd0);
        @(negedge sclk);
        chk("rearm_t21", 32'(ref_req), 32'd1);
        repeat (3) @(negedge sclk);
        chk("sb_final", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
